// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control sequencer owning the PC for the 16-bit CPU
// Optional retired-instruction counter InstrCount enabled by CPU_SEQ_PERFCNT_EN.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Opcode,
  input  logic        Zero,
  input  logic [15:0] BranchOffset,
  output logic [15:0] PC,
  output logic        RegDst,
  output logic        AluSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  AluOp,
  output logic        Branch,
  output logic [2:0]  State,
  output logic        Halted,
  output logic        IllegalOp
`ifdef CPU_SEQ_PERFCNT_EN
  ,
  output logic [15:0] InstrCount
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state;
  logic [3:0]  op_q;
  logic [15:0] pc_seq;
  logic        op_known;
  logic        retire;

  assign pc_seq    = PC + PC_STEP;
  assign op_known  = Opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_HALT};
  assign State     = state;
  assign IllegalOp = (state == S_DECODE) && !op_known;

  // Every edge that updates the PC retires exactly one instruction.
  assign retire = ((state == S_DECODE) && !op_known) ||
                  ((state == S_EXEC) && (op_q == OP_BEQ)) ||
                  ((state == S_MEM) && (op_q != OP_LW)) ||
                  (state == S_WB);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_FETCH;
      PC     <= RESET_PC;
      op_q   <= OP_R;
      Halted <= 1'b0;
      {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp} <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          op_q <= Opcode;
          if (Opcode == OP_HALT) begin
            state  <= S_HALT;
            Halted <= 1'b1;
          end else if (!op_known) begin
            state <= S_FETCH;
            PC    <= pc_seq;
          end else begin
            state  <= S_EXEC;
            RegDst <= (Opcode == OP_R);
            AluSrc <= Opcode inside {OP_LW, OP_SW, OP_ADDI};
            Branch <= (Opcode == OP_BEQ);
            AluOp  <= (Opcode == OP_R)   ? 2'b10 :
                      (Opcode == OP_BEQ) ? 2'b01 : 2'b00;
          end
        end

        S_EXEC: begin
          case (op_q)
            OP_BEQ: begin
              state <= S_FETCH;
              PC    <= Zero ? (pc_seq + BranchOffset) : pc_seq;
              {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp} <= '0;
            end
            OP_LW: begin
              state   <= S_MEM;
              MemRead <= 1'b1;
            end
            OP_SW: begin
              state    <= S_MEM;
              MemWrite <= 1'b1;
            end
            default: begin
              state    <= S_WB;
              RegWrite <= 1'b1;
            end
          endcase
        end

        S_MEM: begin
          if (op_q == OP_LW) begin
            state    <= S_WB;
            MemRead  <= 1'b0;
            RegWrite <= 1'b1;
            MemToReg <= 1'b1;
          end else begin
            state <= S_FETCH;
            PC    <= pc_seq;
            {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp} <= '0;
          end
        end

        S_WB: begin
          state <= S_FETCH;
          PC    <= pc_seq;
          {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp} <= '0;
        end

        S_HALT: state <= S_HALT;

        default: begin
          state <= S_FETCH;
          {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp} <= '0;
        end
      endcase
    end
  end

`ifdef CPU_SEQ_PERFCNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      InstrCount <= 16'd0;
    end else if (retire) begin
      InstrCount <= InstrCount + 16'd1;
    end
  end
`else
  logic retire_unused;
  assign retire_unused = retire;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
// Counter checks compile in only with CPU_SEQ_PERFCNT_EN.
module tb_cpu_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Opcode = 4'd0;
  logic        Zero = 1'b0;
  logic [15:0] BranchOffset = 16'd0;
  logic [15:0] PC;
  logic        RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  AluOp;
  logic [2:0]  State;
  logic        Halted, IllegalOp;
`ifdef CPU_SEQ_PERFCNT_EN
  logic [15:0] InstrCount;
`endif

  cpu_sequencer #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .BranchOffset(BranchOffset), .PC(PC), .RegDst(RegDst), .AluSrc(AluSrc),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .AluOp(AluOp), .Branch(Branch), .State(State),
    .Halted(Halted), .IllegalOp(IllegalOp)
`ifdef CPU_SEQ_PERFCNT_EN
    , .InstrCount(InstrCount)
`endif
  );

  always #5 Clock = ~Clock;

  // {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp[1:0]}
  wire [8:0] ctrl = {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluOp};

  int n_cmp = 0;
  int n_bad = 0;

  int          cyc, rw_cnt, mw_cnt, mr_cnt, il_cnt;
  logic [8:0]  c_exec, c_mem, c_wb;
  logic        pc_moved, halt_bad;
  logic [15:0] pc0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  // Entered at a negedge with State == FETCH; returns at the next FETCH.
  task automatic run_instr(input logic [3:0] op, input logic z, input logic [15:0] off);
    Opcode = op; Zero = z; BranchOffset = off;
    pc0 = PC; cyc = 0; rw_cnt = 0; mw_cnt = 0; mr_cnt = 0; il_cnt = 0;
    c_exec = '0; c_mem = '0; c_wb = '0; pc_moved = 1'b0;
    do begin
      tick();
      cyc++;
      rw_cnt += int'(RegWrite);
      mw_cnt += int'(MemWrite);
      mr_cnt += int'(MemRead);
      il_cnt += int'(IllegalOp);
      case (State)
        3'd2: c_exec = ctrl;
        3'd3: c_mem  = ctrl;
        3'd4: c_wb   = ctrl;
        default: ;
      endcase
      if (State != 3'd0 && PC != pc0) pc_moved = 1'b1;
    end while (State != 3'd0 && cyc < 12);
  endtask

  task automatic expect_instr(input string tag, input int lat, input logic [15:0] pc,
                              input logic [8:0] ex, input logic [8:0] me, input logic [8:0] wb,
                              input int rw, input int mw, input int mr, input int il);
    check({tag, "_lat"},    cyc, lat);
    check({tag, "_pc"},     PC, pc);
    check({tag, "_pchold"}, pc_moved, 0);
    check({tag, "_exec"},   c_exec, ex);
    check({tag, "_mem"},    c_mem, me);
    check({tag, "_wb"},     c_wb, wb);
    check({tag, "_rw"},     rw_cnt, rw);
    check({tag, "_mw"},     mw_cnt, mw);
    check({tag, "_mr"},     mr_cnt, mr);
    check({tag, "_ill"},    il_cnt, il);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    tick(); tick();
    check("rst_pc", PC, 16'h0000);
    check("rst_state", State, 3'd0);
    check("rst_ctrl", ctrl, 9'h000);
    check("rst_halt", Halted, 0);
    check("rst_ill", IllegalOp, 0);
    Reset = 1'b0;

    run_instr(4'b0000, 1'b0, 16'h0000);
    expect_instr("rtype", 4, 16'h0002, 9'h102, 9'h000, 9'h122, 1, 0, 0, 0);
    run_instr(4'b0001, 1'b0, 16'h0000);
    expect_instr("lw", 5, 16'h0004, 9'h080, 9'h090, 9'h0E0, 1, 0, 1, 0);
    run_instr(4'b0011, 1'b0, 16'h0010);
    expect_instr("beq_nt", 3, 16'h0006, 9'h005, 9'h000, 9'h000, 0, 0, 0, 0);
    run_instr(4'b0011, 1'b1, 16'hFFFC);
    expect_instr("beq_back", 3, 16'h0004, 9'h005, 9'h000, 9'h000, 0, 0, 0, 0);
    run_instr(4'b0011, 1'b1, 16'h0010);
    expect_instr("beq_tk", 3, 16'h0016, 9'h005, 9'h000, 9'h000, 0, 0, 0, 0);
    run_instr(4'b0011, 1'b1, 16'hFFE6);
    expect_instr("beq_far", 3, 16'hFFFE, 9'h005, 9'h000, 9'h000, 0, 0, 0, 0);
    run_instr(4'b0010, 1'b0, 16'h0000);
    expect_instr("sw_wrap", 4, 16'h0000, 9'h080, 9'h088, 9'h000, 0, 1, 0, 0);
    run_instr(4'b0111, 1'b0, 16'h0000);
    expect_instr("illegal", 2, 16'h0002, 9'h000, 9'h000, 9'h000, 0, 0, 0, 1);
    run_instr(4'b0100, 1'b0, 16'h0000);
    expect_instr("addi", 4, 16'h0004, 9'h080, 9'h000, 9'h0A0, 1, 0, 0, 0);

    Opcode = 4'b1111;
    tick(); tick();
    check("halt_state", State, 3'd7);
    check("halt_flag", Halted, 1);
    check("halt_ctrl", ctrl, 9'h000);
    halt_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (PC != 16'h0004 || State != 3'd7 || Halted != 1'b1) halt_bad = 1'b1;
    end
    check("halt_frozen", halt_bad, 0);

    Reset = 1'b1; Opcode = 4'b0001;
    tick();
    check("halt_rst_state", State, 3'd0);
    check("halt_rst_pc", PC, 16'h0000);
    check("halt_rst_flag", Halted, 0);
    Reset = 1'b0;
    tick(); tick(); tick();
    check("lw_mem_state", State, 3'd3);
    check("lw_mem_read", MemRead, 1);
    Reset = 1'b1;
    tick();
    check("midrst_pc", PC, 16'h0000);
    check("midrst_state", State, 3'd0);
    check("midrst_read", MemRead, 0);
    check("midrst_write", RegWrite, 0);
    Reset = 1'b0;
    run_instr(4'b0000, 1'b0, 16'h0000);
    expect_instr("post_rst", 4, 16'h0002, 9'h102, 9'h000, 9'h122, 1, 0, 0, 0);

`ifdef CPU_SEQ_PERFCNT_EN
    Reset = 1'b1;
    tick();
    check("cnt_rst", InstrCount, 16'd0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) run_instr(4'b0000, 1'b0, 16'h0000);
    run_instr(4'b0011, 1'b0, 16'h0000);
    Opcode = 4'b1111;
    tick(); tick();
    check("cnt_halt", InstrCount, 16'd4);
    repeat (5) tick();
    check("cnt_hold", InstrCount, 16'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU. It owns the program counter and drives every control input of the datapath: `PC`, `RegDst`, `AluSrc`, `MemToReg`, `RegWrite`, `MemRead`, `MemWrite`, `AluOp` and `Branch`. It consumes the datapath's decoded opcode, ALU `Zero` flag and sign-extended branch offset (`BEQPC`). `PC` is held stable for the whole instruction, so the datapath's combinational fetch sees one instruction per sequence.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `PC_STEP`, default 16'd2: sequential PC increment.

Ports:
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Opcode`  in  4  `Instruction[15:12]` from the datapath; sampled in DECODE.
- `Zero`  in  1  ALU zero flag; sampled in EXEC of BEQ.
- `BranchOffset`  in  16  `BEQPC` from the datapath; sampled in EXEC of BEQ.
- `PC`  out  16  program counter (registered).
- `RegDst`, `AluSrc`, `MemToReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`  out  1 each  datapath controls.
- `AluOp`  out  2  00 add, 01 sub, 10 R-type/funct, 11 unused.
- `State`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- `Halted`  out  1  high while in HALT.
- `IllegalOp`  out  1  one-cycle pulse in DECODE on an unknown opcode.
- `InstrCount`  out  16  retired-instruction count; present only with `CPU_SEQ_PERFCNT_EN`.

## Operation
- Opcodes:
  - 0000 R-type
  - 0001 LW
  - 0010 SW
  - 0011 BEQ
  - 0100 ADDI
  - 1111 HALT
  - all other opcodes are illegal.
- The opcode is latched into an internal register at the DECODE edge. Later states decode from this latched value, not from `Opcode`.
- State sequences per opcode:
  - R-type / ADDI: FETCH, DECODE, EXEC, WB, FETCH.
  - LW: FETCH, DECODE, EXEC, MEM, WB, FETCH.
  - SW: FETCH, DECODE, EXEC, MEM, FETCH.
  - BEQ: FETCH, DECODE, EXEC, FETCH.
  - HALT: FETCH, DECODE, HALT. Stays in HALT until `Reset`; PC is frozen.
  - Illegal: FETCH, DECODE, FETCH. Treated as a NOP, PC advances, `IllegalOp` pulses.
- Outputs are Moore-style, decoded from the state register and the latched opcode:
  - FETCH, DECODE, HALT: all controls 0.
  - EXEC:
    - R-type: `RegDst`=1, `AluSrc`=0, `AluOp`=10.
    - ADDI / LW / SW: `AluSrc`=1, `AluOp`=00.
    - BEQ: `AluSrc`=0, `AluOp`=01, `Branch`=1.
  - MEM: EXEC values are held. LW adds `MemRead`=1; SW adds `MemWrite`=1.
  - WB: EXEC values are held. `RegWrite`=1; LW also drives `MemToReg`=1.
- `RegWrite` and `MemWrite` are each high for exactly one cycle per instruction.
- PC update happens only on the edge that leaves the instruction's last state:
  - Default: `PC <= PC + PC_STEP`.
  - BEQ with `Zero`=1: `PC <= PC + PC_STEP + BranchOffset`.
- PC arithmetic is 16-bit modulo: overflow wraps and no carry is kept.

## Timing
- Reset values: `State`=FETCH, `PC`=`RESET_PC`, every control output 0, `Halted`=0, `IllegalOp`=0, `InstrCount`=0.
- `Reset` dominates every other event, including mid-instruction and in HALT. An interrupted instruction has no further effect and its pending PC update is discarded.
- Instruction latency:
  - BEQ: 3 cycles.
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - Illegal: 2 cycles.
- The first FETCH starts on the cycle after `Reset` deasserts.
- The new PC is visible in the same cycle that FETCH is re-entered.
- `Opcode`, `Zero` and `BranchOffset` must be stable on their sampling edges. No other input timing is assumed.

## Configuration
- `CPU_SEQ_PERFCNT_EN` defined:
  - Adds the `InstrCount` output port.
  - The counter increments on every PC-updating edge, i.e. each retired instruction including illegal NOPs.
  - HALT is not counted.
  - Wraps 16'hFFFF to 0. Cleared by `Reset`.
- `CPU_SEQ_PERFCNT_EN` undefined: the port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold `Reset` 2 cycles with `RESET_PC`=0 -> `PC`=0, `State`=0, all controls 0. First FETCH on the cycle after release.
- R-type then LW: `Opcode`=0000 then 0001 -> R-type shows `RegDst`=1, `AluOp`=10 in EXEC/WB with one `RegWrite` pulse, and PC goes 0 to 2 after 4 cycles. LW shows `MemRead` in MEM, `MemToReg`+`RegWrite` in WB, and PC goes 2 to 4 after 5 cycles.
- BEQ at PC=4 with `BranchOffset`=16'h0010:
  - `Zero`=1 -> `Branch`=1 and `AluOp`=01 in EXEC; next `PC`=16'h0016.
  - `Zero`=0 -> next `PC`=6.
- Wrap: PC=16'hFFFE, SW -> exactly one `MemWrite` pulse, next PC=0. Illegal opcode 0111 -> `IllegalOp` pulse and PC+2 after 2 cycles.
- HALT and reset: `Opcode`=1111 -> `State`=7 and `Halted`=1, PC frozen for 20 cycles. Then assert `Reset` mid-LW (in MEM) -> next cycle `PC`=`RESET_PC`, `MemRead`=0, no `RegWrite`.
- With `CPU_SEQ_PERFCNT_EN`: 3 R-type + 1 BEQ + HALT -> `InstrCount`=4 and it stays 4 in HALT.
